q_value_updater: RTL and testbench

Q_VALUE_UPDATER -- requirements
Module: q_value_updater

---
 rtl/q_value_updater.sv | 214 +++++++++++++++++++++
 tb/tb_q_value_updater.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_value_updater.sv
// Q-learning table updater: a 2**STATE_W x 4 table of signed Q8.8 values updated
// through a FETCH/TARGET/UPDATE/WRITE pipeline. Optional macro: QUPD_TERMINAL_EN.
module q_value_updater #(
    parameter int STATE_W = 4,
    parameter int Q_W     = 16,
    parameter int FRAC_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [STATE_W-1:0]   cur_state,
    input  logic [STATE_W-1:0]   next_state,
    input  logic [3:0]           action,
    input  logic [Q_W-1:0]       reward,
    input  logic [Q_W-1:0]       alpha,
    input  logic [Q_W-1:0]       gamma,
`ifdef QUPD_TERMINAL_EN
    input  logic                 terminal,
`endif
    output logic                 upd_done,
    output logic                 upd_err,
    input  logic [STATE_W-1:0]   rd_state,
    output logic [4*Q_W-1:0]     q_values
);

    localparam int N_ROWS = 1 << STATE_W;
    // Wide enough for a Q_W x (Q_W+1) product plus one carry bit.
    localparam int S_W    = 2*Q_W + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_TARGET = 3'd2,
        S_UPDATE = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [STATE_W-1:0]        r_cur;
    logic [STATE_W-1:0]        r_nxt;
    logic [1:0]                r_slot;
    logic [Q_W-1:0]            r_reward;
    logic [Q_W-1:0]            r_alpha;
    logic [Q_W-1:0]            r_gamma;
`ifdef QUPD_TERMINAL_EN
    logic                      r_terminal;
`endif
    logic signed [Q_W-1:0]     r_q_old;
    logic signed [Q_W-1:0]     r_maxq;
    logic signed [Q_W-1:0]     r_target;
    logic signed [Q_W-1:0]     r_q_new;
    logic                      r_done;
    logic                      r_err;
    logic [4*Q_W-1:0]          r_q_values;

    logic [Q_W-1:0]            w_table [N_ROWS][4];
    logic                      w_accept;
    logic                      w_onehot;
    logic [1:0]                w_slot;
    logic signed [Q_W-1:0]     w_q_old;
    logic signed [Q_W-1:0]     w_maxq;
    logic signed [S_W-1:0]     w_disc_prod;
    logic signed [S_W-1:0]     w_disc;
    logic signed [S_W-1:0]     w_disc_eff;
    logic signed [S_W-1:0]     w_target_sum;
    logic signed [Q_W-1:0]     w_diff;
    logic signed [S_W-1:0]     w_step_prod;
    logic signed [S_W-1:0]     w_step;
    logic signed [S_W-1:0]     w_new_sum;

    function automatic logic signed [S_W-1:0] sext(input logic signed [Q_W-1:0] v);
        return {{(S_W-Q_W){v[Q_W-1]}}, v};
    endfunction

    function automatic logic signed [S_W-1:0] zext(input logic [Q_W-1:0] v);
        return {{(S_W-Q_W){1'b0}}, v};
    endfunction

    // Clamp to the signed Q_W range; in range when all bits above the sign agree.
    function automatic logic signed [Q_W-1:0] sat(input logic signed [S_W-1:0] v);
        if (v[S_W-1:Q_W-1] == {(S_W-Q_W+1){v[S_W-1]}}) begin
            return v[Q_W-1:0];
        end else if (v[S_W-1]) begin
            return {1'b1, {(Q_W-1){1'b0}}};
        end else begin
            return {1'b0, {(Q_W-1){1'b1}}};
        end
    endfunction

    assign upd_ready = (r_state == S_IDLE);
    assign w_accept  = upd_valid && upd_ready;
    assign w_onehot  = (action != 4'd0) && ((action & (action - 4'd1)) == 4'd0);
    assign upd_done  = r_done;
    assign upd_err   = r_err;
    assign q_values  = r_q_values;

    always_comb begin
        w_slot = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (action[i]) begin
                w_slot = 2'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && w_onehot) w_state_next = S_FETCH;
            S_FETCH:  w_state_next = S_TARGET;
            S_TARGET: w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = S_WRITE;
            S_WRITE:  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // One register per table entry so that reset can clear the whole table.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N_ROWS; gi++) begin : g_row
            for (gj = 0; gj < 4; gj++) begin : g_slot
                logic [Q_W-1:0] r_entry;
                logic           w_we;
                assign w_we = (r_state == S_WRITE) && (r_cur == STATE_W'(gi)) && (r_slot == 2'(gj));
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_entry <= '0;
                    end else if (w_we) begin
                        r_entry <= r_q_new;
                    end
                end
                assign w_table[gi][gj] = r_entry;
            end
        end
    endgenerate

    always_comb begin
        w_q_old = w_table[r_cur][r_slot];
        w_maxq  = w_table[r_nxt][0];
        for (int i = 1; i < 4; i++) begin
            if ($signed(w_table[r_nxt][i]) > w_maxq) begin
                w_maxq = w_table[r_nxt][i];
            end
        end
    end

    assign w_disc_prod = zext(r_gamma) * sext(r_maxq);
    assign w_disc      = w_disc_prod >>> FRAC_W;
`ifdef QUPD_TERMINAL_EN
    assign w_disc_eff  = r_terminal ? {S_W{1'b0}} : w_disc;
`else
    assign w_disc_eff  = w_disc;
`endif
    assign w_target_sum = sext(r_reward) + w_disc_eff;

    assign w_diff      = sat(sext(r_target) - sext(r_q_old));
    assign w_step_prod = zext(r_alpha) * sext(w_diff);
    assign w_step      = w_step_prod >>> FRAC_W;
    assign w_new_sum   = sext(r_q_old) + w_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_nxt      <= '0;
            r_slot     <= '0;
            r_reward   <= '0;
            r_alpha    <= '0;
            r_gamma    <= '0;
`ifdef QUPD_TERMINAL_EN
            r_terminal <= 1'b0;
`endif
            r_q_old    <= '0;
            r_maxq     <= '0;
            r_target   <= '0;
            r_q_new    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_q_values <= '0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= (r_state == S_UPDATE);
            r_err      <= w_accept && !w_onehot;
            // Registered read; a same-edge write is not yet visible here.
            r_q_values <= {w_table[rd_state][3], w_table[rd_state][2],
                           w_table[rd_state][1], w_table[rd_state][0]};
            if (w_accept) begin
                r_cur      <= cur_state;
                r_nxt      <= next_state;
                r_slot     <= w_slot;
                r_reward   <= reward;
                r_alpha    <= alpha;
                r_gamma    <= gamma;
`ifdef QUPD_TERMINAL_EN
                r_terminal <= terminal;
`endif
            end
            case (r_state)
                S_FETCH: begin
                    r_q_old <= w_q_old;
                    r_maxq  <= w_maxq;
                end
                S_TARGET: r_target <= sat(w_target_sum);
                S_UPDATE: r_q_new  <= sat(w_new_sum);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_q_value_updater.sv
// Randomized bench for q_value_updater against an integer-arithmetic reference table.
// Define QUPD_TERMINAL_EN on both files to exercise the terminal input.
module tb_q_value_updater;

    localparam int STATE_W = 4;
    localparam int Q_W     = 16;
    localparam int FRAC_W  = 8;
    localparam int N_ROWS  = 16;
`ifdef QUPD_TERMINAL_EN
    localparam bit TERM_EN = 1'b1;
`else
    localparam bit TERM_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                upd_valid = 1'b0;
    logic                upd_ready;
    logic [STATE_W-1:0]  cur_state = '0;
    logic [STATE_W-1:0]  next_state = '0;
    logic [3:0]          action = '0;
    logic [Q_W-1:0]      reward = '0;
    logic [Q_W-1:0]      alpha = '0;
    logic [Q_W-1:0]      gamma = '0;
`ifdef QUPD_TERMINAL_EN
    logic                terminal = 1'b0;
`endif
    logic                upd_done;
    logic                upd_err;
    logic [STATE_W-1:0]  rd_state = '0;
    logic [4*Q_W-1:0]    q_values;

    int                  checks = 0;
    int                  failures = 0;
    longint              model_q [N_ROWS][4];
    logic [63:0]         qv_hist [6];

    always #5 clk = ~clk;

    q_value_updater #(.STATE_W(STATE_W), .Q_W(Q_W), .FRAC_W(FRAC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .cur_state  (cur_state),
        .next_state (next_state),
        .action     (action),
        .reward     (reward),
        .alpha      (alpha),
        .gamma      (gamma),
`ifdef QUPD_TERMINAL_EN
        .terminal   (terminal),
`endif
        .upd_done   (upd_done),
        .upd_err    (upd_err),
        .rd_state   (rd_state),
        .q_values   (q_values)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: plain integers, floor-scaled Q8.8 products, clamping.
    function automatic longint clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint fx_mul(input longint a, input longint b);
        return (a * b) >>> 8;
    endfunction

    function automatic logic [63:0] model_row(input int s);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(model_q[s][i]);
        return v;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < N_ROWS; s++)
            for (int i = 0; i < 4; i++) model_q[s][i] = 0;
    endtask

    task automatic model_apply(input int s, input int ns, input int slot, input longint r,
                               input longint al, input longint ga, input bit term);
        longint maxq, q_old, disc, target, diff;
        maxq = model_q[ns][0];
        for (int i = 1; i < 4; i++) if (model_q[ns][i] > maxq) maxq = model_q[ns][i];
        q_old  = model_q[s][slot];
        disc   = term ? 0 : fx_mul(ga, maxq);
        target = clamp16(r + disc);
        diff   = clamp16(target - q_old);
        model_q[s][slot] = clamp16(q_old + fx_mul(al, diff));
    endtask

    task automatic read_row(input logic [3:0] s, output logic [63:0] v);
        @(negedge clk);
        rd_state = s;
        @(negedge clk);
        v = q_values;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        upd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic run_update(input logic [3:0] s, input logic [3:0] ns, input logic [3:0] act,
                              input logic [15:0] r, input logic [15:0] al, input logic [15:0] ga,
                              input bit term, input bit scramble);
        int  wait_cyc, first_done, n_done, first_err, n_err, slot;
        bit  onehot;
        logic [63:0] row;
        onehot = ($countones(act) == 1);
        slot = 0;
        for (int i = 0; i < 4; i++) if (act[i]) slot = i;
        @(negedge clk);
        wait_cyc = 0;
        while (!upd_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_val("ready_wait", 64'(upd_ready), 64'(1));
        cur_state = s; next_state = ns; action = act;
        reward = r; alpha = al; gamma = ga;
`ifdef QUPD_TERMINAL_EN
        terminal = term;
`endif
        upd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        if (onehot)
            model_apply(int'(s), int'(ns), slot, longint'($signed(r)), longint'(al),
                        longint'(ga), term & TERM_EN);
        first_done = -1; n_done = 0; first_err = -1; n_err = 0;
        for (int k = 0; k < 6; k++) begin
            qv_hist[k] = q_values;
            if (upd_done) begin n_done++; if (first_done < 0) first_done = k; end
            if (upd_err)  begin n_err++;  if (first_err  < 0) first_err  = k; end
            if (k == 0) check_val("busy_ready", 64'(upd_ready), 64'(!onehot));
            if (scramble && onehot && k < 3) begin
                cur_state = 4'($urandom); next_state = 4'($urandom); action = 4'($urandom);
                reward = 16'($urandom); alpha = 16'($urandom); gamma = 16'($urandom);
                upd_valid = 1'b1;
            end else begin
                upd_valid = 1'b0;
            end
            @(negedge clk);
        end
        if (onehot) begin
            check_val("done_lat", 64'(first_done), 64'(3));
            check_val("done_cnt", 64'(n_done), 64'(1));
            check_val("err_cnt",  64'(n_err), 64'(0));
        end else begin
            check_val("err_lat",  64'(first_err), 64'(0));
            check_val("err_cnt",  64'(n_err), 64'(1));
            check_val("done_cnt", 64'(n_done), 64'(0));
        end
        read_row(s, row);
        check_val("row", row, model_row(int'(s)));
        $display("TXN s=%0d ns=%0d act=%b r=%h al=%h ga=%h term=%0d done=%0d err=%0d row=%h",
                 s, ns, act, r, al, ga, term, n_done, n_err, row);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] v;
        logic [63:0] snap;
        int          n_done;
        model_clear();
        do_reset();
        check_val("rst_ready", 64'(upd_ready), 64'(1));
        check_val("rst_done",  64'(upd_done), 64'(0));
        check_val("rst_err",   64'(upd_err), 64'(0));
        check_val("rst_qv",    q_values, 64'h0);

        // Basic update, plus write-edge timing seen through the registered read.
        rd_state = 4'd0;
        run_update(4'd0, 4'd1, 4'b0001, 16'h0100, 16'h0080, 16'h0080, 1'b0, 1'b1);
        check_val("wr_edge_pre",  qv_hist[4], 64'h0);
        check_val("wr_edge_post", qv_hist[5], 64'h0000_0000_0000_0080);
        read_row(4'd0, v);
        check_val("basic_row", v, 64'h0000_0000_0000_0080);

        // Discounted max of the next row.
        run_update(4'd1, 4'd0, 4'b0100, 16'h0200, 16'h0100, 16'h0000, 1'b0, 1'b0);
        run_update(4'd0, 4'd1, 4'b0010, 16'h0000, 16'h0100, 16'h0080, 1'b0, 1'b1);
        read_row(4'd0, v);
        check_val("disc_row", v, 64'h0000_0000_0100_0080);

        // Saturation at the positive rail, including same-row maxq.
        for (int n = 0; n < 3; n++)
            run_update(4'd2, 4'd3, 4'b1000, 16'h7FFF, 16'h0100, 16'h0000, 1'b0, 1'b0);
        for (int n = 0; n < 2; n++)
            run_update(4'd2, 4'd2, 4'b1000, 16'h7FFF, 16'h0100, 16'hFFFF, 1'b0, 1'b0);
        read_row(4'd2, v);
        check_val("sat_row", v, 64'h7FFF_0000_0000_0000);

        // Malformed actions leave the table alone.
        read_row(4'd0, snap);
        run_update(4'd0, 4'd1, 4'b0011, 16'h1234, 16'h0100, 16'h0080, 1'b0, 1'b0);
        run_update(4'd0, 4'd1, 4'b0000, 16'h1234, 16'h0100, 16'h0080, 1'b0, 1'b0);
        read_row(4'd0, v);
        check_val("err_row", v, snap);

`ifdef QUPD_TERMINAL_EN
        run_update(4'd5, 4'd6, 4'b0001, 16'h7FFF, 16'h0100, 16'h0000, 1'b0, 1'b0);
        run_update(4'd4, 4'd5, 4'b0001, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0);
        read_row(4'd4, v);
        check_val("term_row", v, 64'h0000_0000_0000_0100);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [3:0] s, ns, act;
            s  = 4'($urandom_range(0, 15));
            ns = ($urandom_range(0, 3) == 0) ? s : 4'($urandom_range(0, 15));
            act = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            run_update(s, ns, act, 16'($urandom), 16'($urandom_range(0, 16'h01FF)),
                       16'($urandom), 1'($urandom_range(0, 1)), 1'(n % 2));
        end

        // Reset while in UPDATE: the pending write is dropped and the table cleared.
        @(negedge clk);
        cur_state = 4'd3; next_state = 4'd4; action = 4'b0001;
        reward = 16'h0400; alpha = 16'h0100; gamma = 16'h0000;
        upd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        n_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (upd_done) n_done++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check_val("midrst_ready", 64'(upd_ready), 64'(1));
        repeat (4) begin
            @(negedge clk);
            if (upd_done) n_done++;
        end
        check_val("midrst_done", 64'(n_done), 64'(0));
        for (int s = 0; s < N_ROWS; s++) begin
            read_row(4'(s), v);
            check_val("midrst_row", v, 64'h0);
        end

        run_update(4'd0, 4'd1, 4'b0001, 16'h0100, 16'h0080, 16'h0080, 1'b0, 1'b0);
        read_row(4'd0, v);
        check_val("post_rst_row", v, 64'h0000_0000_0000_0080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
